make_instruc_asm: RTL and testbench

MAKE_INSTRUC_ASM -- requirements
Module: make_instruc

---
 rtl/make_instruc_asm.sv | 103 ++++++++++
 tb/tb_make_instruc_asm.sv | 133 +++++++++++++
 2 files changed

// File: rtl/make_instruc_asm.sv
// Assembles N_BYTES UART bytes into one NB_INSTR-bit instruction word.
// Byte order is MSB-first by default; define MAKE_INSTRUC_LSB_FIRST_EN for little-endian.
module make_instruc_asm #(
    parameter int unsigned NB_BYTE  = 8,
    parameter int unsigned N_BYTES  = 4,
    parameter int unsigned NB_INSTR = NB_BYTE * N_BYTES
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_rx_done,
    input  logic [NB_BYTE-1:0]  entrada,
    output logic                ready_instruc,
    output logic [NB_INSTR-1:0] o_registro
);

    localparam int unsigned CNT_W = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam int unsigned LAST  = N_BYTES - 1;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        DONE    = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NB_INSTR-1:0] shreg_q, shreg_d;
    logic [NB_INSTR-1:0] word_q, word_d;
    logic                ready_q, ready_d;
    logic [NB_INSTR-1:0] shifted_c;
    logic                last_byte_c;

    // Shift expressions stay legal when N_BYTES == 1 (no zero-width slices).
`ifdef MAKE_INSTRUC_LSB_FIRST_EN
    assign shifted_c = (shreg_q >> NB_BYTE) | (NB_INSTR'(entrada) << (NB_INSTR - NB_BYTE));
`else
    assign shifted_c = (shreg_q << NB_BYTE) | NB_INSTR'(entrada);
`endif

    assign last_byte_c = (cnt_q == CNT_W'(LAST));

    // Next-state and output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        word_d  = word_q;
        ready_d = ready_q;

        if (i_rx_done) begin
            shreg_d = shifted_c;
            if (last_byte_c) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end

            case (state_q)
                COLLECT: begin
                    if (last_byte_c) begin
                        state_d = DONE;
                        word_d  = shifted_c;
                        ready_d = 1'b1;
                    end
                end
                DONE: begin
                    // Accepted byte is byte 0 of the next word; completes at once if N_BYTES == 1.
                    if (last_byte_c) begin
                        state_d = DONE;
                        word_d  = shifted_c;
                        ready_d = 1'b1;
                    end else begin
                        state_d = COLLECT;
                        ready_d = 1'b0;
                    end
                end
                default: begin
                    state_d = COLLECT;
                    ready_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            shreg_q <= '0;
            word_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            word_q  <= word_d;
            ready_q <= ready_d;
        end
    end

    assign ready_instruc = ready_q;
    assign o_registro    = word_q;

endmodule

// File: tb/tb_make_instruc_asm.sv
// Directed bench for make_instruc_asm: expected outputs are queued per driven cycle and checked after the edge.
module tb_make_instruc_asm;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_rx_done;
    logic [7:0]  entrada;
    logic        ready_instruc;
    logic [31:0] o_registro;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rdy;
        logic [31:0] word;
        string       tag;
    } exp_t;

    exp_t sb[$];

    make_instruc_asm dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_rx_done     (i_rx_done),
        .entrada       (entrada),
        .ready_instruc (ready_instruc),
        .o_registro    (o_registro)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] mk(input logic [7:0] b0, input logic [7:0] b1,
                                       input logic [7:0] b2, input logic [7:0] b3);
`ifdef MAKE_INSTRUC_LSB_FIRST_EN
        return {b3, b2, b1, b0};
`else
        return {b0, b1, b2, b3};
`endif
    endfunction

    task automatic step(input logic rst_n, input logic rx, input logic [7:0] b,
                        input logic exp_rdy, input logic [31:0] exp_word, input string tag);
        exp_t e;
        exp_t got;
        i_reset   = rst_n;
        i_rx_done = rx;
        entrada   = b;
        e.rdy  = exp_rdy;
        e.word = exp_word;
        e.tag  = tag;
        sb.push_back(e);
        @(posedge i_clk);
        #1;
        got = sb.pop_front();
        checks++;
        assert (ready_instruc === got.rdy) else begin
            errors++;
            $error("FAIL %s ready_instruc: observed %b expected %b", got.tag, ready_instruc, got.rdy);
        end
        checks++;
        assert (o_registro === got.word) else begin
            errors++;
            $error("FAIL %s o_registro: observed %h expected %h", got.tag, o_registro, got.word);
        end
    endtask

    logic [31:0] w1, w2, w3, w4, w5;

    initial begin
        i_reset   = 1'b0;
        i_rx_done = 1'b0;
        entrada   = 8'h00;
        w1 = mk(8'hFF, 8'h00, 8'hFF, 8'h00);
        w2 = mk(8'h12, 8'h34, 8'h56, 8'h78);
        w3 = mk(8'hAA, 8'hBB, 8'hCC, 8'hDD);
        w4 = mk(8'h01, 8'h02, 8'h03, 8'h04);
        w5 = mk(8'h05, 8'h06, 8'h07, 8'h08);

        // Reset, including reset winning over a valid byte
        step(1'b0, 1'b0, 8'h00, 1'b0, 32'h0, "reset");
        step(1'b0, 1'b1, 8'hAA, 1'b0, 32'h0, "reset_prio");

        // FF,00,FF then a long gap then 00
        step(1'b1, 1'b1, 8'hFF, 1'b0, 32'h0, "w1_b0");
        step(1'b1, 1'b1, 8'h00, 1'b0, 32'h0, "w1_b1");
        step(1'b1, 1'b1, 8'hFF, 1'b0, 32'h0, "w1_b2");
        for (int i = 0; i < 10; i++)
            step(1'b1, 1'b0, 8'($urandom_range(0, 255)), 1'b0, 32'h0, "w1_gap");
        step(1'b1, 1'b1, 8'h00, 1'b1, w1, "w1_done");

        // DONE holds while idle, entrada ignored
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, 8'hF0, 1'b1, w1, "done_hold");

        // Next word: ready clears on first byte, word unchanged until complete
        step(1'b1, 1'b1, 8'h12, 1'b0, w1, "w2_b0");
        step(1'b1, 1'b1, 8'h34, 1'b0, w1, "w2_b1");
        step(1'b1, 1'b0, 8'h99, 1'b0, w1, "w2_gap");
        step(1'b1, 1'b1, 8'h56, 1'b0, w1, "w2_b2");
        step(1'b1, 1'b1, 8'h78, 1'b1, w2, "w2_done");

        // Partial word discarded by reset
        step(1'b1, 1'b1, 8'h11, 1'b0, w2, "part_b0");
        step(1'b1, 1'b1, 8'h22, 1'b0, w2, "part_b1");
        step(1'b0, 1'b1, 8'h33, 1'b0, 32'h0, "mid_reset");
        step(1'b1, 1'b1, 8'hAA, 1'b0, 32'h0, "w3_b0");
        step(1'b1, 1'b1, 8'hBB, 1'b0, 32'h0, "w3_b1");
        step(1'b1, 1'b1, 8'hCC, 1'b0, 32'h0, "w3_b2");
        step(1'b1, 1'b1, 8'hDD, 1'b1, w3, "w3_done");

        // Back-to-back bytes 01..08
        step(1'b1, 1'b1, 8'h01, 1'b0, w3, "bb_01");
        step(1'b1, 1'b1, 8'h02, 1'b0, w3, "bb_02");
        step(1'b1, 1'b1, 8'h03, 1'b0, w3, "bb_03");
        step(1'b1, 1'b1, 8'h04, 1'b1, w4, "bb_04");
        step(1'b1, 1'b1, 8'h05, 1'b0, w4, "bb_05");
        step(1'b1, 1'b1, 8'h06, 1'b0, w4, "bb_06");
        step(1'b1, 1'b1, 8'h07, 1'b0, w4, "bb_07");
        step(1'b1, 1'b1, 8'h08, 1'b1, w5, "bb_08");
        step(1'b1, 1'b0, 8'h5A, 1'b1, w5, "final_hold");

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain: observed %0d expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
